pe_array_feeder: RTL and testbench

//  Producer side of the PE block array interface: turns one tile command plus weight-row
//  and activation-vector streams into is_wt/wt_in/data_in for one PE block. Loads

---
 rtl/pe_feed_pkg.sv | 22 ++
 rtl/pe_skew_line.sv | 25 ++
 rtl/pe_array_feeder.sv | 136 +++++++++++++
 tb/tb_pe_array_feeder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_feed_pkg.sv
// Shared types and constants for the PE array feeder.
package pe_feed_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_WT = 2'd1,
    STREAM  = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic [2:0] PE_SHARE_NONE = 3'b000;
  localparam logic [2:0] PE_SHARE_ROW  = 3'b001;
  localparam logic [2:0] PE_SHARE_COL  = 3'b010;
  localparam logic [2:0] PE_SHARE_DIAG = 3'b011;
  localparam logic [2:0] PE_SHARE_ALL  = 3'b100;

  // A vector needs depth cycles to cross the rows and column cycles to reach the staged output.
  function automatic int acc_lat_default(input int depth, input int column);
    return depth + column;
  endfunction

endpackage

// File: rtl/pe_skew_line.sv
// Fixed-length delay line for one activation lane; synchronous clear.
module pe_skew_line #(
  parameter int bit_width = 8,
  parameter int DELAY     = 1
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [bit_width-1:0] din,
  output logic [bit_width-1:0] dout
);

  logic [bit_width-1:0] stage [DELAY];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DELAY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DELAY; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DELAY-1];

endmodule

// File: rtl/pe_array_feeder.sv
// Feeds one PE block: loads weight rows, streams diagonally skewed activations,
// tracks which staged results are real, and signals tile completion.
module pe_array_feeder
  import pe_feed_pkg::*;
#(
  parameter int bit_width       = 8,
  parameter int systolic_depth  = 4,
  parameter int systolic_column = 16,
  parameter int ACC_LAT         = acc_lat_default(systolic_depth, systolic_column),
  parameter int NVEC_W          = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [NVEC_W-1:0]                    cmd_nvec,
  input  logic                                 wt_valid,
  output logic                                 wt_ready,
  input  logic [bit_width*systolic_column-1:0] wt_row,
  input  logic                                 act_valid,
  output logic                                 act_ready,
  input  logic [bit_width*systolic_depth-1:0]  act_vec,
  output logic                                 is_wt,
  output logic [bit_width*systolic_column-1:0] wt_in,
  output logic [bit_width*systolic_depth-1:0]  data_in,
  output logic                                 acc_valid,
  output logic                                 done
);

  localparam int WC_W = $clog2(systolic_depth + 1);
  localparam int DC_W = $clog2(ACC_LAT + 1);
  localparam logic [WC_W-1:0] WT_LAST = WC_W'(systolic_depth - 1);
  localparam logic [DC_W-1:0] DR_LAST = DC_W'(ACC_LAT - 1);

  state_t              state;
  logic [NVEC_W-1:0]   nvec;
  logic [NVEC_W-1:0]   vec_cnt;
  logic [WC_W-1:0]     wt_cnt;
  logic [DC_W-1:0]     drain_cnt;
  logic [ACC_LAT-1:0]  tag;

  logic wt_fire;
  logic act_fire;
  logic [bit_width*systolic_depth-1:0] inject;

  assign wt_fire  = wt_valid & wt_ready;
  assign act_fire = act_valid & act_ready;
  // The array never stalls, so a missing vector becomes an all-zero bubble.
  assign inject   = act_fire ? act_vec : '0;
  assign acc_valid = tag[ACC_LAT-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      wt_ready  <= 1'b0;
      act_ready <= 1'b0;
      is_wt     <= 1'b0;
      wt_in     <= '0;
      done      <= 1'b0;
      nvec      <= '0;
      vec_cnt   <= '0;
      wt_cnt    <= '0;
      drain_cnt <= '0;
      tag       <= '0;
    end else begin
      is_wt <= 1'b0;
      wt_in <= '0;
      done  <= 1'b0;
      tag   <= {tag[ACC_LAT-2:0], act_fire};
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            nvec      <= cmd_nvec;
            wt_cnt    <= '0;
            vec_cnt   <= '0;
            cmd_ready <= 1'b0;
            wt_ready  <= 1'b1;
            state     <= LOAD_WT;
          end
        end
        LOAD_WT: begin
          if (wt_fire) begin
            is_wt  <= 1'b1;
            wt_in  <= wt_row;
            wt_cnt <= wt_cnt + WC_W'(1);
            if (wt_cnt == WT_LAST) begin
              wt_ready <= 1'b0;
              if (nvec == '0) begin
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                act_ready <= 1'b1;
                state     <= STREAM;
              end
            end
          end
        end
        STREAM: begin
          if (act_fire) begin
            vec_cnt <= vec_cnt + NVEC_W'(1);
            if (vec_cnt == nvec - NVEC_W'(1)) begin
              act_ready <= 1'b0;
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Long enough for the last tag to leave the pipe and the skew lines to empty.
          if (drain_cnt == DR_LAST) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + DC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < systolic_depth; k++) begin : g_lane
    pe_skew_line #(
      .bit_width(bit_width),
      .DELAY    (k + 1)
    ) u_skew (
      .clk (clk),
      .clr (!rst_n),
      .din (inject[k*bit_width +: bit_width]),
      .dout(data_in[k*bit_width +: bit_width])
    );
  end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Scoreboard bench for pe_array_feeder: handshakes predict outputs, a monitor compares them.
module tb_pe_array_feeder;

  localparam int LAT = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [15:0]  cmd_nvec;
  logic         wt_valid;
  logic         wt_ready;
  logic [127:0] wt_row;
  logic         act_valid;
  logic         act_ready;
  logic [31:0]  act_vec;
  logic         is_wt;
  logic [127:0] wt_in;
  logic [31:0]  data_in;
  logic         acc_valid;
  logic         done;

  pe_array_feeder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_nvec (cmd_nvec),
    .wt_valid (wt_valid),
    .wt_ready (wt_ready),
    .wt_row   (wt_row),
    .act_valid(act_valid),
    .act_ready(act_ready),
    .act_vec  (act_vec),
    .is_wt    (is_wt),
    .wt_in    (wt_in),
    .data_in  (data_in),
    .acc_valid(acc_valid),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model state: expected outputs keyed by the cycle they must appear in.
  typedef struct { int t; logic [127:0] d; } wt_exp_t;
  wt_exp_t     wt_q[$];
  int          acc_q[$];
  int          done_q[$];
  logic [31:0] hist [int];
  bit          busy;
  int          tile_nvec, nwt, nact;
  bit          expect_cr;

  logic [31:0] exp_data;
  logic [31:0] hv;
  wt_exp_t     we;
  int          t;

  always @(negedge clk) begin
    if (!rst_n) begin
      wt_q.delete(); acc_q.delete(); done_q.delete(); hist.delete();
      busy = 0; nwt = 0; nact = 0; tile_nvec = 0; expect_cr = 0;
    end else begin
      if (expect_cr) begin
        chk("cmd_ready_after_done", cmd_ready, 1);
        expect_cr = 0;
      end
      if (is_wt) begin
        if (wt_q.size() == 0) chk("unexpected_is_wt", 1, 0);
        else begin
          we = wt_q.pop_front();
          chk("is_wt_cycle", cyc, we.t);
          chk("wt_in_row", wt_in, we.d);
        end
      end else begin
        chk("wt_in_zero", wt_in, 0);
      end
      while (wt_q.size() > 0 && wt_q[0].t < cyc) begin
        chk("is_wt_missing", 0, 1);
        void'(wt_q.pop_front());
      end
      exp_data = '0;
      for (int k = 0; k < 4; k++) begin
        if (hist.exists(cyc - k - 1)) begin
          hv = hist[cyc - k - 1];
          exp_data[k*8 +: 8] = hv[k*8 +: 8];
        end
      end
      chk("data_in", data_in, exp_data);
      if (acc_valid) begin
        if (acc_q.size() == 0) chk("unexpected_acc_valid", 1, 0);
        else begin
          t = acc_q.pop_front();
          chk("acc_valid_cycle", cyc, t);
        end
      end
      while (acc_q.size() > 0 && acc_q[0] < cyc) begin
        chk("acc_valid_missing", 0, 1);
        void'(acc_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          t = done_q.pop_front();
          chk("done_cycle", cyc, t);
        end
        busy = 0;
        expect_cr = 1;
      end
      while (done_q.size() > 0 && done_q[0] < cyc) begin
        chk("done_missing", 0, 1);
        void'(done_q.pop_front());
      end
      if (cmd_ready) chk("cmd_ready_only_idle", busy, 0);
      if (wt_ready)  chk("wt_ready_legal", busy && nwt < 4, 1);
      if (act_ready) chk("act_ready_legal", busy && nwt == 4 && nact < tile_nvec, 1);
      // Handshakes seen now complete at the coming edge.
      if (cmd_valid && cmd_ready) begin
        busy = 1; tile_nvec = int'(cmd_nvec); nwt = 0; nact = 0;
      end
      if (wt_valid && wt_ready) begin
        we.t = cyc + 1; we.d = wt_row;
        wt_q.push_back(we);
        nwt++;
        if (nwt == 4 && tile_nvec == 0) done_q.push_back(cyc + 1);
      end
      if (act_valid && act_ready) begin
        hist[cyc] = act_vec;
        acc_q.push_back(cyc + LAT);
        nact++;
        if (nact == tile_nvec) done_q.push_back(cyc + LAT + 1);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [15:0] n);
    bit ok = 0;
    cmd_valid = 1; cmd_nvec = n;
    for (int b = 0; b < 300 && !ok; b++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
    end
    step();
    cmd_valid = 0;
    if (!ok) chk("cmd_timeout", 0, 1);
  endtask

  task automatic send_wt(input logic [127:0] row);
    bit ok = 0;
    wt_valid = 1; wt_row = row;
    for (int b = 0; b < 300 && !ok; b++) begin
      @(negedge clk);
      if (wt_ready) ok = 1;
    end
    step();
    wt_valid = 0;
    if (!ok) chk("wt_timeout", 0, 1);
  endtask

  task automatic send_act(input logic [31:0] v);
    bit ok = 0;
    act_valid = 1; act_vec = v;
    for (int b = 0; b < 300 && !ok; b++) begin
      @(negedge clk);
      if (act_ready) ok = 1;
    end
    step();
    act_valid = 0;
    if (!ok) chk("act_timeout", 0, 1);
  endtask

  function automatic logic [127:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load_rand_wts();
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 2)) step();
      send_wt(rand_row());
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int b = 0; b < 300 && !ok; b++) begin
      @(negedge clk);
      if (cmd_ready && done_q.size() == 0 && acc_q.size() == 0 && !busy) ok = 1;
    end
    step();
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 0; cmd_valid = 0; wt_valid = 0; act_valid = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wt_ready", wt_ready, 0);
    chk("rst_act_ready", act_ready, 0);
    chk("rst_is_wt", is_wt, 0);
    chk("rst_wt_in", wt_in, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_acc_valid", acc_valid, 0);
    chk("rst_done", done, 0);
    step();
    rst_n = 1;
  endtask

  task automatic run_tile(input int n);
    send_cmd(16'(n));
    load_rand_wts();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) step();
      send_act($urandom);
    end
    wait_idle();
  endtask

  initial begin
    rst_n = 0; cmd_valid = 0; cmd_nvec = '0; wt_valid = 0; wt_row = '0;
    act_valid = 0; act_vec = '0;
    do_reset();

    // Weight load with a one-cycle gap.
    send_cmd(16'd2);
    send_wt({16{8'h01}});
    send_wt({16{8'h02}});
    step();
    send_wt({16{8'h03}});
    send_wt({16{8'h04}});
    send_act($urandom);
    send_act($urandom);
    wait_idle();

    // Single vector shows the per-lane skew.
    send_cmd(16'd1);
    load_rand_wts();
    send_act({8'd4, 8'd3, 8'd2, 8'd1});
    wait_idle();

    // Bubble pattern 1,0,1,1.
    send_cmd(16'd3);
    load_rand_wts();
    send_act($urandom);
    step();
    send_act($urandom);
    send_act($urandom);
    wait_idle();

    // Empty tile finishes right after the weights.
    send_cmd(16'd0);
    load_rand_wts();
    wait_idle();

    for (int i = 0; i < 5; i++) run_tile(int'($urandom_range(1, 6)));

    // Reset in the middle of streaming drops in-flight results.
    send_cmd(16'd5);
    load_rand_wts();
    send_act($urandom);
    send_act($urandom);
    do_reset();
    repeat (40) step();

    run_tile(2);

    chk("wt_q_empty", wt_q.size(), 0);
    chk("acc_q_empty", acc_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
